// File: rtl/bp_pkg.sv
// Shared definitions for the dynamic branch predictor: counter encoding,
// allocation defaults and PC index/tag extraction helpers.
package bp_pkg;

   // 2-bit saturating counter encoding
   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   // Counter values written on allocation and on reset
   localparam logic [1:0] ALLOC_CTR_TAKEN    = CTR_WT;
   localparam logic [1:0] ALLOC_CTR_NOTTAKEN = CTR_WNT;
   localparam logic [1:0] RESET_CTR          = CTR_WNT;

   // Table index: pc[indexBits+1:2], returned zero-extended to 64 bits
   function automatic logic [63:0] pcIndex(input logic [63:0] pc,
                                           input int unsigned indexBits);
      return (pc >> 2) & ((64'(1) << indexBits) - 64'(1));
   endfunction

   // Tag: pc[indexBits+tagBits+1:indexBits+2], returned zero-extended to 64 bits
   function automatic logic [63:0] pcTag(input logic [63:0] pc,
                                         input int unsigned indexBits,
                                         input int unsigned tagBits);
      return (pc >> (indexBits + 2)) & ((64'(1) << tagBits) - 64'(1));
   endfunction

endpackage

// File: rtl/dyn_branch_predictor_if.sv
// Fetch lookup, resolution update and statistics signals of the predictor.
interface dyn_branch_predictor_if #(
   parameter int unsigned CNT_W = 32
);
   logic [63:0]      fetch_pc;
   logic             predict_hit;
   logic             predict_taken;
   logic [63:0]      predict_next_pc;
   logic             update_valid;
   logic [63:0]      update_pc;
   logic             update_taken;
   logic [63:0]      update_target;
   logic             update_pred_taken;
   logic [CNT_W-1:0] branch_count;
   logic [CNT_W-1:0] mispredict_count;

   // Pipeline side: supplies fetch PC and resolutions, consumes predictions
   modport master (
      output fetch_pc, update_valid, update_pc, update_taken,
             update_target, update_pred_taken,
      input  predict_hit, predict_taken, predict_next_pc,
             branch_count, mispredict_count
   );

   // Predictor side
   modport slave (
      input  fetch_pc, update_valid, update_pc, update_taken,
             update_target, update_pred_taken,
      output predict_hit, predict_taken, predict_next_pc,
             branch_count, mispredict_count
   );
endinterface

// File: rtl/dyn_branch_predictor_sat_counter2.sv
// Combinational next state of a 2-bit saturating direction counter.
module sat_counter2
   import bp_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       taken,
   output logic [1:0] ctrNext
);

   // Step toward the observed outcome, holding at the end points
   always_comb begin
      ctrNext = ctr;
      if (taken) begin
         if (ctr != CTR_ST) ctrNext = ctr + 2'd1;
      end else begin
         if (ctr != CTR_SNT) ctrNext = ctr - 2'd1;
      end
   end

endmodule

// File: rtl/dyn_branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup on fetch_pc,
// trained by resolved branches, plus saturating branch/mispredict statistics.
module dyn_branch_predictor
   import bp_pkg::*;
#(
   parameter int unsigned INDEX_BITS = 4,
   parameter int unsigned TAG_BITS   = 8,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   dyn_branch_predictor_if.slave bp
);

   localparam int unsigned ENTRIES = 1 << INDEX_BITS;

   logic                validQ  [ENTRIES];
   logic [TAG_BITS-1:0] tagQ    [ENTRIES];
   logic [63:0]         targetQ [ENTRIES];
   logic [1:0]          ctrQ    [ENTRIES];

   logic [CNT_W-1:0]    branchCountQ;
   logic [CNT_W-1:0]    mispredictCountQ;

   logic [INDEX_BITS-1:0] lkIdx;
   logic [TAG_BITS-1:0]   lkTag;
   logic                  lkHit;
   logic                  lkTaken;

   logic [INDEX_BITS-1:0] upIdx;
   logic [TAG_BITS-1:0]   upTag;
   logic                  upHit;
   logic [1:0]            upCtrNext;

   // Lookup from registered state only; updates become visible next cycle
   always_comb begin
      lkIdx   = INDEX_BITS'(pcIndex(bp.fetch_pc, INDEX_BITS));
      lkTag   = TAG_BITS'(pcTag(bp.fetch_pc, INDEX_BITS, TAG_BITS));
      lkHit   = validQ[lkIdx] && (tagQ[lkIdx] == lkTag);
      lkTaken = lkHit && ctrQ[lkIdx][1];
   end

   assign bp.predict_hit      = lkHit;
   assign bp.predict_taken    = lkTaken;
   assign bp.predict_next_pc  = lkTaken ? targetQ[lkIdx] : bp.fetch_pc + 64'd4;
   assign bp.branch_count     = branchCountQ;
   assign bp.mispredict_count = mispredictCountQ;

   // Locate the entry touched by the resolving branch
   always_comb begin
      upIdx = INDEX_BITS'(pcIndex(bp.update_pc, INDEX_BITS));
      upTag = TAG_BITS'(pcTag(bp.update_pc, INDEX_BITS, TAG_BITS));
      upHit = validQ[upIdx] && (tagQ[upIdx] == upTag);
   end

   sat_counter2 u_satCounter (
      .ctr     (ctrQ[upIdx]),
      .taken   (bp.update_taken),
      .ctrNext (upCtrNext)
   );

   // Table training: train on hit, allocate/replace on miss; reset wins
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            validQ[i]  <= 1'b0;
            tagQ[i]    <= '0;
            targetQ[i] <= '0;
            ctrQ[i]    <= RESET_CTR;
         end
      end else if (bp.update_valid) begin
         if (upHit) begin
            ctrQ[upIdx] <= upCtrNext;
            if (bp.update_taken) targetQ[upIdx] <= bp.update_target;
         end else begin
            validQ[upIdx]  <= 1'b1;
            tagQ[upIdx]    <= upTag;
            targetQ[upIdx] <= bp.update_target;
            ctrQ[upIdx]    <= bp.update_taken ? ALLOC_CTR_TAKEN : ALLOC_CTR_NOTTAKEN;
         end
      end
   end

   // Saturating statistics counters
   always_ff @(posedge clk) begin
      if (reset) begin
         branchCountQ     <= '0;
         mispredictCountQ <= '0;
      end else if (bp.update_valid) begin
         if (branchCountQ != '1) branchCountQ <= branchCountQ + CNT_W'(1);
         if ((bp.update_taken != bp.update_pred_taken) && (mispredictCountQ != '1))
            mispredictCountQ <= mispredictCountQ + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_dyn_branch_predictor.sv
// Directed testbench for dyn_branch_predictor with hand-computed expectations.
module tb_dyn_branch_predictor;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;

   dyn_branch_predictor_if #(.CNT_W(32)) bp ();

   dyn_branch_predictor #(.INDEX_BITS(4), .TAG_BITS(8), .CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bp    (bp)
   );

   always #5 clk = ~clk;

   // Advance one clock, settle just after the active edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one resolution for a single edge
   task automatic upd(input logic [63:0] pc, input logic taken,
                      input logic [63:0] target, input logic predTaken);
      bp.update_valid      = 1'b1;
      bp.update_pc         = pc;
      bp.update_taken      = taken;
      bp.update_target     = target;
      bp.update_pred_taken = predTaken;
      tick();
      bp.update_valid      = 1'b0;
   endtask

   task automatic look(input string tag, input logic [63:0] pc, input logic hit,
                       input logic taken, input logic [63:0] nextPc);
      bp.fetch_pc = pc;
      #1;
      chk({tag, ".hit"}, 64'(bp.predict_hit), 64'(hit));
      chk({tag, ".taken"}, 64'(bp.predict_taken), 64'(taken));
      chk({tag, ".next"}, bp.predict_next_pc, nextPc);
   endtask

   task automatic stats(input string tag, input logic [31:0] bc, input logic [31:0] mc);
      chk({tag, ".bc"}, 64'(bp.branch_count), 64'(bc));
      chk({tag, ".mc"}, 64'(bp.mispredict_count), 64'(mc));
   endtask

   initial begin
      reset                = 1'b1;
      bp.fetch_pc          = 64'h40;
      bp.update_valid      = 1'b0;
      bp.update_pc         = '0;
      bp.update_taken      = 1'b0;
      bp.update_target     = '0;
      bp.update_pred_taken = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // 1: state after reset
      look("rst", 64'h40, 1'b0, 1'b0, 64'h44);
      stats("rst", 0, 0);

      // 2: allocate taken; same-cycle lookup still sees old state
      bp.update_valid      = 1'b1;
      bp.update_pc         = 64'h40;
      bp.update_taken      = 1'b1;
      bp.update_target     = 64'h100;
      bp.update_pred_taken = 1'b0;
      look("alloc.pre", 64'h40, 1'b0, 1'b0, 64'h44);
      tick();
      bp.update_valid = 1'b0;
      look("alloc.post", 64'h40, 1'b1, 1'b1, 64'h100);
      stats("alloc", 1, 1);

      // 3: counter walk from WT; not-taken updates carry a bogus target
      upd(64'h40, 1'b0, 64'h999, 1'b1);        // WT -> WNT
      look("nt1", 64'h40, 1'b1, 1'b0, 64'h44);
      upd(64'h40, 1'b0, 64'h999, 1'b1);        // WNT -> SNT
      look("nt2", 64'h40, 1'b1, 1'b0, 64'h44);
      upd(64'h40, 1'b0, 64'h999, 1'b0);        // SNT stays SNT
      look("nt3", 64'h40, 1'b1, 1'b0, 64'h44);
      upd(64'h40, 1'b1, 64'h100, 1'b0);        // SNT -> WNT
      look("t1", 64'h40, 1'b1, 1'b0, 64'h44);
      upd(64'h40, 1'b1, 64'h100, 1'b0);        // WNT -> WT
      look("t2", 64'h40, 1'b1, 1'b1, 64'h100);
      stats("walk", 6, 5);
      upd(64'h40, 1'b1, 64'h100, 1'b1);        // WT -> ST
      upd(64'h40, 1'b0, 64'h777, 1'b1);        // ST -> WT, target kept
      look("keep", 64'h40, 1'b1, 1'b1, 64'h100);
      stats("keep", 8, 6);

      // 4: aliasing on index 0 with a different tag
      look("alias.pre", 64'h440, 1'b0, 1'b0, 64'h444);
      upd(64'h440, 1'b1, 64'h800, 1'b0);
      look("alias.new", 64'h440, 1'b1, 1'b1, 64'h800);
      look("alias.old", 64'h40, 1'b0, 1'b0, 64'h44);
      look("lowbits", 64'h443, 1'b1, 1'b1, 64'h800);
      stats("alias", 9, 7);

      // 5: reset with a concurrent update discards it and clears everything
      reset = 1'b1;
      upd(64'h80, 1'b1, 64'h200, 1'b0);
      reset = 1'b0;
      stats("rstupd", 0, 0);
      look("rstupd.a", 64'h440, 1'b0, 1'b0, 64'h444);
      look("rstupd.b", 64'h80, 1'b0, 1'b0, 64'h84);

      // 5: statistics over three resolutions
      upd(64'hC0, 1'b1, 64'h300, 1'b1);
      upd(64'hC0, 1'b0, 64'h300, 1'b1);
      upd(64'hC0, 1'b1, 64'h300, 1'b1);
      stats("stat3", 3, 1);
      look("stat3", 64'hC0, 1'b1, 1'b1, 64'h300);

      // 6: fall-through address wraps modulo 2^64
      look("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
